// File: rtl/gnn_pkg.sv
// Shared sizes, word-count map and state encoding for the GNN input loader.
package gnn_pkg;
  localparam int DATA_W  = 5;
  localparam int N_NODES = 4;
  localparam int N_FEAT  = 4;
  localparam int N_HID   = 4;
  localparam int N_OUT   = 2;

  localparam int FEAT_WORDS  = N_NODES * N_FEAT;
  localparam int W1_WORDS    = N_FEAT * N_HID;
  localparam int W2_WORDS    = N_HID * N_OUT;
  localparam int FRAME_WORDS = FEAT_WORDS + W1_WORDS + W2_WORDS;
  localparam int CNT_W       = 6;

  localparam int X_BITS  = FEAT_WORDS * DATA_W;
  localparam int W1_BITS = W1_WORDS * DATA_W;
  localparam int W2_BITS = W2_WORDS * DATA_W;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FIRE = 2'd1,
    BUSY = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] last_word_idx(input logic mode);
    return mode ? CNT_W'(FRAME_WORDS - 1) : CNT_W'(FEAT_WORDS - 1);
  endfunction
endpackage

// File: rtl/gnn_word_demux.sv
// Decodes the stream word index into per-slot write strobes for the x, w1 and w2 banks.
// Purely combinational; no backpressure of its own.
module gnn_word_demux
  import gnn_pkg::*;
(
  input  logic [CNT_W-1:0]      word_idx,
  input  logic                  wr_en,
  output logic [FEAT_WORDS-1:0] x_we,
  output logic [W1_WORDS-1:0]   w1_we,
  output logic [W2_WORDS-1:0]   w2_we
);

  always_comb begin
    x_we  = '0;
    w1_we = '0;
    w2_we = '0;
    for (int i = 0; i < FEAT_WORDS; i++) begin
      x_we[i] = wr_en && (word_idx == CNT_W'(i));
    end
    for (int i = 0; i < W1_WORDS; i++) begin
      w1_we[i] = wr_en && (word_idx == CNT_W'(FEAT_WORDS + i));
    end
    for (int i = 0; i < W2_WORDS; i++) begin
      w2_we[i] = wr_en && (word_idx == CNT_W'(FEAT_WORDS + W1_WORDS + i));
    end
  end

endmodule

// File: rtl/gnn_input_loader.sv
// Assembles a serial operand stream into parallel x/w1/w2 registers and starts the compute top.
// in_ready pulses one cycle after the FIRE state; s_ready is low from FIRE until compute_done.
module gnn_input_loader
  import gnn_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               load_w,
  input  logic               flush,
  input  logic               compute_done,
  output logic [X_BITS-1:0]  x_flat,
  output logic [W1_BITS-1:0] w1_flat,
  output logic [W2_BITS-1:0] w2_flat,
  output logic               in_ready,
  output logic               busy,
  output logic [7:0]         frame_cnt
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 mode_q, mode_d;
  logic [X_BITS-1:0]    x_q, x_d;
  logic [W1_BITS-1:0]   w1_q, w1_d;
  logic [W2_BITS-1:0]   w2_q, w2_d;
  logic                 in_ready_q, in_ready_d;
  logic                 busy_q, busy_d;
  logic [7:0]           frame_cnt_q, frame_cnt_d;

  logic                 accept;
  logic                 first_word;
  logic                 last_word;
  logic [FEAT_WORDS-1:0] x_we;
  logic [W1_WORDS-1:0]   w1_we;
  logic [W2_WORDS-1:0]   w2_we;

  assign s_ready    = (state_q == LOAD);
  assign accept     = s_valid && s_ready;
  assign first_word = (cnt_q == '0);
  // The frame length is decided by load_w on the very word being accepted when it is the first one.
  assign last_word  = accept && (cnt_q == last_word_idx(first_word ? load_w : mode_q));

  gnn_word_demux u_demux (
    .word_idx (cnt_q),
    .wr_en    (accept),
    .x_we     (x_we),
    .w1_we    (w1_we),
    .w2_we    (w2_we)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      LOAD: begin
        if (accept) begin
          cnt_d = last_word ? '0 : cnt_q + CNT_W'(1);
          if (last_word) state_d = FIRE;
        end
      end
      FIRE:    state_d = BUSY;
      BUSY:    if (compute_done) state_d = LOAD;
      default: state_d = LOAD;
    endcase

    if (accept && first_word) mode_d = load_w;

    if (flush) begin
      state_d = LOAD;
      cnt_d   = '0;
    end

    // The start pulse and frame count follow the FIRE register, so a flush in FIRE still fires.
    in_ready_d = (state_q == FIRE);
    if (state_q == FIRE) frame_cnt_d = frame_cnt_q + 8'd1;
    busy_d = (state_d != LOAD);
  end

  always_comb begin
    x_d  = x_q;
    w1_d = w1_q;
    w2_d = w2_q;
    for (int i = 0; i < FEAT_WORDS; i++) begin
      if (x_we[i]) x_d[i*DATA_W +: DATA_W] = s_data;
    end
    for (int i = 0; i < W1_WORDS; i++) begin
      if (w1_we[i]) w1_d[i*DATA_W +: DATA_W] = s_data;
    end
    for (int i = 0; i < W2_WORDS; i++) begin
      if (w2_we[i]) w2_d[i*DATA_W +: DATA_W] = s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      x_q         <= '0;
      w1_q        <= '0;
      w2_q        <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      x_q         <= x_d;
      w1_q        <= w1_d;
      w2_q        <= w2_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign x_flat    = x_q;
  assign w1_flat   = w1_q;
  assign w2_flat   = w2_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_gnn_input_loader.sv
// Self-checking bench for gnn_input_loader: directed frames plus a randomized stream against a frame-level model.
module tb_gnn_input_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [4:0]  s_data;
  logic        load_w;
  logic        flush;
  logic        compute_done;
  logic [79:0] x_flat;
  logic [79:0] w1_flat;
  logic [39:0] w2_flat;
  logic        in_ready;
  logic        busy;
  logic [7:0]  frame_cnt;

  always #5 clk = ~clk;

  gnn_input_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .load_w       (load_w),
    .flush        (flush),
    .compute_done (compute_done),
    .x_flat       (x_flat),
    .w1_flat      (w1_flat),
    .w2_flat      (w2_flat),
    .in_ready     (in_ready),
    .busy         (busy),
    .frame_cnt    (frame_cnt)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_acc = 0;
  int ir_count = 0;
  int ir_cyc   = 0;

  logic [4:0] fw [40];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Frame-level reference: a word lands in slot k of the concatenated x|w1|w2 space;
  // a frame ends after 16 or 40 words, then one start cycle, then a wait for compute_done.
  logic [4:0] mx [16];
  logic [4:0] mw1 [16];
  logic [4:0] mw2 [8];
  int  mk;
  bit  mmode, m_load, m_fire, m_wait, m_pulse;
  int  m_frames;

  always @(posedge clk) begin : model
    bit acc;
    bit done;
    bit nmode;
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        mx[i]  <= 5'd0;
        mw1[i] <= 5'd0;
      end
      for (int i = 0; i < 8; i++) mw2[i] <= 5'd0;
      mk <= 0; mmode <= 1'b0; m_load <= 1'b1; m_fire <= 1'b0;
      m_wait <= 1'b0; m_pulse <= 1'b0; m_frames <= 0;
    end else begin
      acc   = s_valid && m_load;
      nmode = (acc && mk == 0) ? load_w : mmode;
      done  = acc && (mk + 1 == (nmode ? 40 : 16));
      if (acc) begin
        if (mk < 16)      mx[mk]       <= s_data;
        else if (mk < 32) mw1[mk - 16] <= s_data;
        else              mw2[mk - 32] <= s_data;
      end
      mmode   <= nmode;
      m_pulse <= m_fire;
      if (m_fire) m_frames <= (m_frames + 1) % 256;
      if (flush) begin
        m_load <= 1'b1; m_fire <= 1'b0; m_wait <= 1'b0; mk <= 0;
      end else if (done) begin
        m_load <= 1'b0; m_fire <= 1'b1; mk <= 0;
      end else if (acc) begin
        mk <= mk + 1;
      end else if (m_fire) begin
        m_fire <= 1'b0; m_wait <= 1'b1;
      end else if (m_wait && compute_done) begin
        m_wait <= 1'b0; m_load <= 1'b1;
      end
    end
  end

  logic [79:0] ex, e1;
  logic [39:0] e2;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 16; i++) begin
        ex[i*5 +: 5] = mx[i];
        e1[i*5 +: 5] = mw1[i];
      end
      for (int i = 0; i < 8; i++) e2[i*5 +: 5] = mw2[i];
      check("s_ready",   80'(s_ready),   80'(m_load));
      check("in_ready",  80'(in_ready),  80'(m_pulse));
      check("busy",      80'(busy),      80'(m_fire || m_wait));
      check("frame_cnt", 80'(frame_cnt), 80'(m_frames));
      check("x_flat",    x_flat,         ex);
      check("w1_flat",   w1_flat,        e1);
      check("w2_flat",   80'(w2_flat),   80'(e2));
      if (in_ready) begin
        ir_count <= ir_count + 1;
        ir_cyc   <= cyc;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_word(input logic [4:0] d, input logic lw, input logic fl);
    int  waited;
    bit  ok;
    waited = 0;
    s_valid = 1'b1; s_data = d; load_w = lw; flush = fl;
    do begin
      ok = s_ready;
      tick();
      waited++;
    end while (!ok && waited < 200);
    check("accept_timeout", 80'(ok), 80'(1));
    last_acc = cyc;
    s_valid = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic mode, input bit gapped);
    for (int i = 0; i < n; i++) begin
      send_word(fw[i], (i == 0) ? mode : ~mode, 1'b0);
      if (gapped) tick();
    end
  endtask

  task automatic release_compute(input int hold);
    compute_done = 1'b0;
    repeat (hold) tick();
    compute_done = 1'b1;
    tick();
    compute_done = 1'b0;
  endtask

  task automatic randomize_fw();
    for (int i = 0; i < 40; i++) fw[i] = 5'($urandom_range(0, 31));
  endtask

  task automatic check_frame(input int n);
    logic [79:0] cx, c1;
    logic [39:0] c2;
    for (int i = 0; i < 16; i++) begin
      cx[i*5 +: 5] = fw[i];
      c1[i*5 +: 5] = fw[16 + i];
    end
    for (int i = 0; i < 8; i++) c2[i*5 +: 5] = fw[32 + i];
    check("frame_x", x_flat, cx);
    if (n == 40) begin
      check("frame_w1", w1_flat, c1);
      check("frame_w2", 80'(w2_flat), 80'(c2));
    end
  endtask

  logic [79:0] sevens;
  int ir_before;

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; load_w = 1'b0;
    flush = 1'b0; compute_done = 1'b0;
    for (int i = 0; i < 16; i++) sevens[i*5 +: 5] = 5'd7;
    repeat (3) tick();
    check("rst_frame_cnt", 80'(frame_cnt), 80'(0));
    check("rst_busy",      80'(busy),      80'(0));
    check("rst_x",         x_flat,         80'(0));
    rst_n = 1'b1;
    tick();
    check("rst_s_ready", 80'(s_ready), 80'(1));

    // Full weighted frame with valid held high.
    fw = '{5'd4, 5'd2, 5'd4, 5'd1, 5'd6, 5'd4, 5'd4, 5'd1,
           5'd8, 5'd6, 5'd4, 5'd1, 5'd6, 5'd4, 5'd4, 5'd1,
           5'd3, 5'd2, 5'd13, 5'd26, 5'd23, 5'd1, 5'd28, 5'd14,
           5'd3, 5'd6, 5'd17, 5'd15, 5'd9, 5'd22, 5'd15, 5'd22,
           5'd0, 5'd31, 5'd3, 5'd21, 5'd20, 5'd17, 5'd17, 5'd6};
    ir_before = ir_count;
    send_frame(40, 1'b1, 1'b0);
    check("f1_x0",  80'(x_flat[4:0]),    80'(4));
    check("f1_w1",  80'(w1_flat[79:75]), 80'(22));
    check("f1_w49", 80'(w2_flat[24:20]), 80'(20));
    release_compute(3);
    check("f1_pulses",  80'(ir_count - ir_before), 80'(1));
    check("f1_latency", 80'(ir_cyc - last_acc),    80'(1));
    check("f1_frames",  80'(frame_cnt),            80'(1));

    // Feature-only frame, then a stall in BUSY with valid asserted.
    for (int i = 0; i < 16; i++) fw[i] = 5'd7;
    ir_before = ir_count;
    send_frame(16, 1'b0, 1'b0);
    check("f2_x",   x_flat,                 sevens);
    check("f2_w1",  80'(w1_flat[79:75]),    80'(22));
    check("f2_w49", 80'(w2_flat[24:20]),    80'(20));
    s_valid = 1'b1; s_data = 5'd31; load_w = 1'b1; compute_done = 1'b0;
    repeat (11) tick();
    check("stall_s_ready", 80'(s_ready), 80'(0));
    check("stall_x",       x_flat,       sevens);
    s_valid = 1'b0; compute_done = 1'b1;
    tick();
    compute_done = 1'b0;
    check("stall_release", 80'(s_ready),             80'(1));
    check("f2_pulses",     80'(ir_count - ir_before), 80'(1));
    check("f2_frames",     80'(frame_cnt),            80'(2));

    // Gapped stream.
    randomize_fw();
    ir_before = ir_count;
    send_frame(40, 1'b1, 1'b1);
    check_frame(40);
    release_compute(2);
    check("gap_pulses", 80'(ir_count - ir_before), 80'(1));

    // Flush on word 20, then a complete frame.
    randomize_fw();
    ir_before = ir_count;
    send_frame(20, 1'b1, 1'b0);
    send_word(5'd9, 1'b0, 1'b1);
    randomize_fw();
    send_frame(40, 1'b1, 1'b0);
    check_frame(40);
    release_compute(2);
    check("flush_pulses", 80'(ir_count - ir_before), 80'(1));

    // Asynchronous reset in the middle of a frame.
    randomize_fw();
    send_frame(10, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("arst_x",        x_flat,         80'(0));
    check("arst_w1",       w1_flat,        80'(0));
    check("arst_w2",       80'(w2_flat),   80'(0));
    check("arst_frames",   80'(frame_cnt), 80'(0));
    check("arst_in_ready", 80'(in_ready),  80'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();
    randomize_fw();
    ir_before = ir_count;
    send_frame(40, 1'b1, 1'b0);
    check_frame(40);
    release_compute(2);
    check("post_rst_pulses", 80'(ir_count - ir_before), 80'(1));
    check("post_rst_frames", 80'(frame_cnt),            80'(1));

    // Randomized stream against the model.
    repeat (2500) begin
      s_valid      = ($urandom_range(0, 3) != 0);
      s_data       = 5'($urandom_range(0, 31));
      load_w       = 1'($urandom_range(0, 1));
      compute_done = ($urandom_range(0, 2) == 0);
      flush        = ($urandom_range(0, 49) == 0);
      tick();
    end
    s_valid = 1'b0; compute_done = 1'b0; flush = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
